// File: rtl/tt_um_seq_divider.sv
// Sequential restoring divider (8-bit / 4-bit) in the TinyTapeout pin frame, one quotient bit per clock.
// Define DIV_EARLY_EXIT_EN to finish in one cycle when the dividend is smaller than a non-zero divisor.
module tt_um_seq_divider #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               r_startQ;
  logic [DVD_W-1:0]   r_dvd;
  logic [DVS_W-1:0]   r_dvs;
  logic [DVS_W-1:0]   r_p;
  logic [2:0]         r_count;
  logic [DVD_W-1:0]   r_quotient;
  logic [DVS_W-1:0]   r_remainder;
  logic               r_divByZero;

  logic [DVS_W-1:0]   w_dvsIn;
  logic               w_start;
  logic               w_outSel;
  logic               w_startEdge;
  logic               w_zeroDvs;
  logic               w_early;
  logic [DVS_W:0]     w_t;
  logic [DVS_W:0]     w_diff;
  logic               w_ge;
  logic [DVS_W-1:0]   w_pNext;
  logic [DVD_W-1:0]   w_dvdNext;
  logic               w_unused;

  assign w_dvsIn     = uio_in[3:0];
  assign w_start     = uio_in[4];
  assign w_outSel    = uio_in[5];
  assign w_startEdge = w_start & ~r_startQ;
  assign w_zeroDvs   = (w_dvsIn == '0);

`ifdef DIV_EARLY_EXIT_EN
  assign w_early = ~w_zeroDvs & (ui_in < {{(DVD_W-DVS_W){1'b0}}, w_dvsIn});
`else
  assign w_early = 1'b0;
`endif

  // One restoring step: shift the next dividend bit into the partial remainder and try a subtract.
  assign w_t       = {r_p, r_dvd[DVD_W-1]};
  assign w_diff    = w_t - {1'b0, r_dvs};
  assign w_ge      = (w_t >= {1'b0, r_dvs});
  assign w_pNext   = w_ge ? w_diff[DVS_W-1:0] : w_t[DVS_W-1:0];
  assign w_dvdNext = {r_dvd[DVD_W-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_startEdge) begin
          if (w_zeroDvs || w_early) begin
            w_nextState = DONE;
          end else begin
            w_nextState = RUN;
          end
        end
      end
      RUN: begin
        if (r_count == 3'd0) begin
          w_nextState = DONE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Dividend register doubles as the quotient shift register; results land only on the last step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_startQ    <= 1'b0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_p         <= '0;
      r_count     <= 3'd0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divByZero <= 1'b0;
    end else begin
      r_startQ <= w_start;
      case (r_state)
        IDLE, DONE: begin
          if (w_startEdge) begin
            r_dvd       <= ui_in;
            r_dvs       <= w_dvsIn;
            r_divByZero <= 1'b0;
            r_p         <= '0;
            r_count     <= 3'd7;
            if (w_zeroDvs) begin
              r_quotient  <= '1;
              r_remainder <= ui_in[DVS_W-1:0];
              r_divByZero <= 1'b1;
            end else if (w_early) begin
              r_quotient  <= '0;
              r_remainder <= ui_in[DVS_W-1:0];
            end
          end
        end
        RUN: begin
          r_dvd   <= w_dvdNext;
          r_p     <= w_pNext;
          r_count <= r_count - 3'd1;
          if (r_count == 3'd0) begin
            r_quotient  <= w_dvdNext;
            r_remainder <= w_pNext;
          end
        end
        default: ;
      endcase
    end
  end

  assign uo_out   = w_outSel ? {{(DVD_W-DVS_W){1'b0}}, r_remainder} : r_quotient;
  assign uio_out  = {r_divByZero, (r_state == DONE), (r_state == RUN), 5'b0_0000};
  assign uio_oe   = 8'b1110_0000;
  assign w_unused = &{ena, uio_in[7:6], w_diff[DVS_W], 1'b0};

endmodule

// File: tb/tb_tt_um_seq_divider.sv
// Scoreboard bench for tt_um_seq_divider: stimulus pushes expected results, a monitor checks each completion.
module tb_tt_um_seq_divider;

  typedef struct {
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       divByZero;
    int         busyCycles;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic [3:0] divisor = 4'd0;
  logic       start = 1'b0;
  logic       outSel = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  exp_t sbQueue[$];
  int   assertCount = 0;
  int   failCount = 0;
  int   busyCount = 0;
  logic prevDone = 1'b0;

  logic busyW, doneW, dbzW;
  assign uio_in = {2'b00, outSel, start, divisor};
  assign busyW  = uio_out[5];
  assign doneW  = uio_out[6];
  assign dbzW   = uio_out[7];

  tt_um_seq_divider dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issues one start pulse; the expected result is queued only for operations meant to complete.
  task automatic applyStimulus(input logic [7:0] dvd, input logic [3:0] dvs, input logic [7:0] expQ,
                               input logic [3:0] expR, input logic expDbz, input int expBusy,
                               input bit expectResult);
    exp_t e;
    @(negedge clk);
    ui_in = dvd;
    divisor = dvs;
    start = 1'b1;
    if (expectResult) begin
      e.quotient = expQ;
      e.remainder = expR;
      e.divByZero = expDbz;
      e.busyCycles = expBusy;
      sbQueue.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitForDone(input int limit, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (doneW) seen = 1'b1;
    end
    if (!seen) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: owns out_sel, counts busy cycles and checks every rising done against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        busyCount = 0;
        prevDone = 1'b0;
      end else begin
        if (busyW && doneW) checkOutput("busyDoneExclusive", 32'd1, 32'd0);
        if (busyW) busyCount++;
        if (doneW && !prevDone) begin
          if (sbQueue.size() == 0) begin
            checkOutput("unexpectedDone", 32'd1, 32'd0);
          end else begin
            e = sbQueue.pop_front();
            outSel = 1'b0;
            #1 checkOutput("quotient", uo_out, e.quotient);
            outSel = 1'b1;
            #1 checkOutput("remainder", uo_out, {4'b0, e.remainder});
            checkOutput("divByZero", dbzW, e.divByZero);
            checkOutput("busyCycles", busyCount, e.busyCycles);
          end
          busyCount = 0;
        end
        prevDone = doneW;
      end
    end
  end

  initial begin
    int smallBusy;
`ifdef DIV_EARLY_EXIT_EN
    smallBusy = 0;
`else
    smallBusy = 8;
`endif
    repeat (2) @(negedge clk);
    checkOutput("resetUoOut", uo_out, 8'h00);
    checkOutput("resetUioOut", uio_out, 8'h00);
    checkOutput("uioOe", uio_oe, 8'hE0);
    rst_n = 1'b1;

    applyStimulus(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8, 1'b1);
    waitForDone(20, "div200by7");
    applyStimulus(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8, 1'b1);
    repeat (2) @(negedge clk);
    waitForDone(20, "div255by15");
    applyStimulus(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8, 1'b1);
    repeat (2) @(negedge clk);
    waitForDone(20, "div255by1");
    applyStimulus(8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 8, 1'b1);
    repeat (2) @(negedge clk);
    waitForDone(20, "div100by3");

    pulseReset();
    applyStimulus(8'd5, 4'd0, 8'hFF, 4'd5, 1'b1, 0, 1'b1);
    waitForDone(20, "divByZero");
    checkOutput("dbzFlag", dbzW, 1'b1);

    pulseReset();
    applyStimulus(8'd3, 4'd9, 8'd0, 4'd3, 1'b0, smallBusy, 1'b1);
    waitForDone(20, "div3by9");

    pulseReset();
    @(negedge clk);
    ui_in = 8'd20;
    divisor = 4'd4;
    start = 1'b1;
    sbQueue.push_back('{quotient: 8'd5, remainder: 4'd0, divByZero: 1'b0, busyCycles: 8});
    waitForDone(20, "heldStart");
    repeat (20) @(negedge clk);
    checkOutput("heldStartDone", doneW, 1'b1);
    checkOutput("heldStartBusy", busyW, 1'b0);
    start = 1'b0;
    @(negedge clk);

    applyStimulus(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8, 1'b1);
    repeat (2) @(negedge clk);
    ui_in = 8'd50;
    divisor = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitForDone(20, "startDuringRun");

    applyStimulus(8'd200, 4'd7, 8'd0, 4'd0, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abortBusy", busyW, 1'b0);
    checkOutput("abortDone", doneW, 1'b0);
    checkOutput("abortUoOut", uo_out, 8'h00);
    rst_n = 1'b1;
    applyStimulus(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8, 1'b1);
    waitForDone(20, "afterAbort");

    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", sbQueue.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
